// File: rtl/lamp_card_target.sv
// lamp_card_target: bus target with four lamp registers and four ADC read channels.
// The strobes, board select, address and test qualifier pass through a SYNC_STAGES-deep
// synchronizer. data_in is registered for one stage only.
// A READ, WRITE, FAULT state machine drives a registered data_out/data_oe.
// Optional feature: defining LAMP_CARD_TARGET_TESTADDR_EN makes a read entered with
// test_addr=1 return {BOARD_ID, addr, 1'b1}.
module lamp_card_target #(
    parameter logic [3:0]  BOARD_ID    = 4'h0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  board_x,
    input  logic [2:0]  addr,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        test_addr,
    input  logic        lamp_reset_n,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [31:0] adc_in,
    output logic [31:0] lamp_out,
    output logic [7:0]  access_count,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Synchronizer bundle layout:
    // [10] lamp_reset_n, [9] rd_n, [8] wr_n, [7] test_addr, [6:4] addr, [3:0] board_x.
    // The active-low controls reset to their inactive level.
    localparam logic [10:0] SYNC_RST = {1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 4'h0};

    logic [10:0] sync_q [SYNC_STAGES];
    logic [10:0] sync_d [SYNC_STAGES];
    logic [10:0] sync_out;

    logic [7:0]  din_q, din_d;
    state_t      state_q, state_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  lamp_q [4];
    logic [7:0]  lamp_d [4];
    logic [7:0]  data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic [7:0]  count_q, count_d;
    logic        fault_q, fault_d;

    logic [7:0]  adc_ch [4];
    logic        lrst_s, rd_s, wr_s, tst_s;
    logic [2:0]  addr_s;
    logic [3:0]  board_s;
    logic        selected;
    logic [7:0]  rd_val;

    // Synchronizer shift: stage 0 samples the pins, each later stage copies the previous one.
    always_comb begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            if (i == 0) begin
                sync_d[i] = {lamp_reset_n, rd_n, wr_n, test_addr, addr, board_x};
            end else begin
                sync_d[i] = sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign lrst_s   = sync_out[10];
    assign rd_s     = sync_out[9];
    assign wr_s     = sync_out[8];
    assign tst_s    = sync_out[7];
    assign addr_s   = sync_out[6:4];
    assign board_s  = sync_out[3:0];
    assign selected = (board_s == BOARD_ID);
    assign din_d    = data_in;

    // Split the ADC bus into its four 8-bit channels.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            adc_ch[i] = adc_in[8*i +: 8];
        end
    end

`ifdef LAMP_CARD_TARGET_TESTADDR_EN
    // Value captured on read entry. A test-address read returns the identity pattern instead.
    always_comb begin
        if (tst_s) begin
            rd_val = {BOARD_ID, addr_s, 1'b1};
        end else if (addr_s[2]) begin
            rd_val = adc_ch[addr_s[1:0]];
        end else begin
            rd_val = lamp_q[addr_s[1:0]];
        end
    end
`else
    logic unused_test_addr;
    assign unused_test_addr = tst_s;

    // Value captured on read entry: a lamp register for addr 0..3, an ADC snapshot for 4..7.
    always_comb begin
        if (addr_s[2]) begin
            rd_val = adc_ch[addr_s[1:0]];
        end else begin
            rd_val = lamp_q[addr_s[1:0]];
        end
    end
`endif

    // Next-state and next-output logic for the access state machine.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        count_d    = count_q;
        fault_d    = fault_q;
        for (int unsigned i = 0; i < 4; i++) begin
            lamp_d[i] = lamp_q[i];
        end

        if (!lrst_s) begin
            // Card reset: abandon any access without committing it, and keep the counter and fault flag.
            state_d   = ST_IDLE;
            data_oe_d = 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                lamp_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (selected) begin
                        if (!rd_s && !wr_s) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else if (!rd_s) begin
                            state_d    = ST_READ;
                            addr_d     = addr_s;
                            data_out_d = rd_val;
                            data_oe_d  = 1'b1;
                        end else if (!wr_s) begin
                            state_d = ST_WRITE;
                            addr_d  = addr_s;
                            wdata_d = din_q;
                        end
                    end
                end
                ST_READ: begin
                    if (!wr_s) begin
                        state_d   = ST_FAULT;
                        data_oe_d = 1'b0;
                        fault_d   = 1'b1;
                    end else if (rd_s) begin
                        state_d   = ST_IDLE;
                        data_oe_d = 1'b0;
                        count_d   = count_q + 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (!rd_s) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else if (wr_s) begin
                        state_d = ST_IDLE;
                        count_d = count_q + 8'd1;
                        if (!addr_q[2]) begin
                            lamp_d[addr_q[1:0]] = wdata_q;
                        end
                    end else begin
                        wdata_d = din_q;
                    end
                end
                ST_FAULT: begin
                    data_oe_d = 1'b0;
                    if (rd_s && wr_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    data_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State, synchronizer and output registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                lamp_q[i] <= '0;
            end
            din_q      <= '0;
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            count_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int unsigned i = 0; i < 4; i++) begin
                lamp_q[i] <= lamp_d[i];
            end
            din_q      <= din_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_oe      = data_oe_q;
    assign access_count = count_q;
    assign fault        = fault_q;
    assign lamp_out     = {lamp_q[3], lamp_q[2], lamp_q[1], lamp_q[0]};

endmodule

// File: tb/tb_lamp_card_target.sv
// Directed bench for lamp_card_target with BOARD_ID=3 and SYNC_STAGES=2.
// Every expected value below is hand-computed.
module tb_lamp_card_target;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  board_x = 4'h0;
    logic [2:0]  addr = 3'd0;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic        test_addr = 1'b0;
    logic        lamp_reset_n = 1'b1;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [31:0] adc_in = 32'h0;
    logic [31:0] lamp_out;
    logic [7:0]  access_count;
    logic        fault;

    int checks = 0;
    int errors = 0;

    lamp_card_target #(.BOARD_ID(4'h3), .SYNC_STAGES(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .board_x      (board_x),
        .addr         (addr),
        .rd_n         (rd_n),
        .wr_n         (wr_n),
        .test_addr    (test_addr),
        .lamp_reset_n (lamp_reset_n),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .adc_in       (adc_in),
        .lamp_out     (lamp_out),
        .access_count (access_count),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold wr_n low for 6 clocks, then release it and let the commit settle.
    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        addr    = a;
        data_in = d;
        wr_n    = 1'b0;
        tick(6);
        wr_n = 1'b1;
        tick(4);
    endtask

    initial begin
        // Reset state.
        #2;
        chk("rst_oe", {31'b0, data_oe}, 32'd0);
        chk("rst_dout", {24'b0, data_out}, 32'd0);
        chk("rst_lamp", lamp_out, 32'd0);
        chk("rst_cnt", {24'b0, access_count}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Write 8'hA5 to addr 2, then 8'h3C to addr 1.
        board_x = 4'h3;
        addr = 3'd2; data_in = 8'hA5; wr_n = 1'b0;
        tick(4);
        chk("wr_oe_low", {31'b0, data_oe}, 32'd0);
        tick(2);
        wr_n = 1'b1;
        tick(4);
        chk("wr_a5_lamp", lamp_out, 32'h00A5_0000);
        chk("wr_a5_cnt", {24'b0, access_count}, 32'd1);
        do_write(3'd1, 8'h3C);
        chk("wr_3c_lamp", lamp_out, 32'h00A5_3C00);
        chk("wr_3c_cnt", {24'b0, access_count}, 32'd2);

        // Read addr 5. The ADC channel 1 snapshot must survive a mid-strobe change.
        adc_in = 32'h4433_7C11;
        addr = 3'd5; rd_n = 1'b0;
        tick(2);
        chk("rd_lat_e2", {31'b0, data_oe}, 32'd0);
        tick(1);
        chk("rd_lat_e3", {31'b0, data_oe}, 32'd1);
        chk("rd_adc_val", {24'b0, data_out}, 32'h7C);
        adc_in = 32'h4433_0011;
        tick(3);
        chk("rd_adc_hold", {24'b0, data_out}, 32'h7C);
        chk("rd_adc_oe", {31'b0, data_oe}, 32'd1);
        rd_n = 1'b1;
        tick(2);
        chk("rd_end_e2", {31'b0, data_oe}, 32'd1);
        tick(1);
        chk("rd_end_e3", {31'b0, data_oe}, 32'd0);
        chk("rd_adc_cnt", {24'b0, access_count}, 32'd3);

        // Read lamp reg 2. Deselecting mid-read must not abort the access.
        addr = 3'd2; rd_n = 1'b0;
        tick(3);
        chk("rd_lamp_val", {24'b0, data_out}, 32'hA5);
        board_x = 4'h2;
        tick(3);
        chk("rd_desel_oe", {31'b0, data_oe}, 32'd1);
        rd_n = 1'b1;
        tick(4);
        chk("rd_desel_cnt", {24'b0, access_count}, 32'd4);

        // A write while deselected must be ignored.
        addr = 3'd0; data_in = 8'hFF; wr_n = 1'b0;
        tick(4);
        chk("desel_oe", {31'b0, data_oe}, 32'd0);
        tick(2);
        wr_n = 1'b1;
        tick(4);
        chk("desel_lamp", lamp_out, 32'h00A5_3C00);
        chk("desel_cnt", {24'b0, access_count}, 32'd4);

        // A write to addr 5 is discarded but still completes as an access.
        board_x = 4'h3;
        do_write(3'd5, 8'hEE);
        chk("wr_adc_lamp", lamp_out, 32'h00A5_3C00);
        chk("wr_adc_cnt", {24'b0, access_count}, 32'd5);

        // Contention: rd_n falls during a write.
        addr = 3'd3; data_in = 8'h77; wr_n = 1'b0;
        tick(4);
        rd_n = 1'b0;
        tick(3);
        chk("flt_set", {31'b0, fault}, 32'd1);
        chk("flt_oe", {31'b0, data_oe}, 32'd0);
        rd_n = 1'b1; wr_n = 1'b1;
        tick(4);
        chk("flt_lamp", lamp_out, 32'h00A5_3C00);
        chk("flt_cnt", {24'b0, access_count}, 32'd5);
        chk("flt_sticky", {31'b0, fault}, 32'd1);

        // Read addr 6 with test_addr=1. The result depends on the build option.
        adc_in = 32'h4433_0011;
        addr = 3'd6; test_addr = 1'b1; rd_n = 1'b0;
        tick(3);
        chk("tst_oe", {31'b0, data_oe}, 32'd1);
`ifdef LAMP_CARD_TARGET_TESTADDR_EN
        chk("tst_val", {24'b0, data_out}, 32'h3D);
`else
        chk("tst_val", {24'b0, data_out}, 32'h33);
`endif
        rd_n = 1'b1; test_addr = 1'b0;
        tick(4);
        chk("tst_cnt", {24'b0, access_count}, 32'd6);

        // A fresh reset, one write, then 255 reads wrap the counter to 8'h00.
        reset = 1'b1;
        tick(1);
        chk("rst2_fault", {31'b0, fault}, 32'd0);
        chk("rst2_lamp", lamp_out, 32'd0);
        reset = 1'b0;
        tick(2);
        do_write(3'd0, 8'h5A);
        chk("wrap_wr_lamp", lamp_out, 32'h0000_005A);
        addr = 3'd0;
        for (int i = 0; i < 254; i++) begin
            rd_n = 1'b0; tick(4);
            rd_n = 1'b1; tick(4);
        end
        chk("wrap_ff", {24'b0, access_count}, 32'hFF);
        rd_n = 1'b0; tick(4);
        chk("wrap_rd_val", {24'b0, data_out}, 32'h5A);
        rd_n = 1'b1; tick(4);
        chk("wrap_00", {24'b0, access_count}, 32'h00);

        // Card reset clears the lamp registers and keeps the counter.
        lamp_reset_n = 1'b0;
        tick(4);
        chk("lrst_lamp", lamp_out, 32'd0);
        chk("lrst_cnt", {24'b0, access_count}, 32'h00);
        lamp_reset_n = 1'b1;
        tick(3);

        // Card reset during a write: no commit and no count.
        do_write(3'd1, 8'h12);
        chk("lrst_pre_lamp", lamp_out, 32'h0000_1200);
        addr = 3'd2; data_in = 8'h99; wr_n = 1'b0;
        tick(4);
        lamp_reset_n = 1'b0;
        tick(4);
        lamp_reset_n = 1'b1; wr_n = 1'b1;
        tick(4);
        chk("lrst_wr_lamp", lamp_out, 32'd0);
        chk("lrst_wr_cnt", {24'b0, access_count}, 32'd1);
        chk("lrst_wr_oe", {31'b0, data_oe}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lamp_card_target.md
LAMP_CARD_TARGET -- requirements
Module: lamp_card_target

Interface
REQ-001 SHALL have parameter BOARD_ID, default 4'h0, board-select value this target answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on bus control inputs (legal 2..3).
REQ-003 clock  input  1  system clock, 27 MHz nominal.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 board_x  input  4  board select from initiator.
REQ-006 addr  input  3  register address.
REQ-007 rd_n  input  1  read strobe, active low.
REQ-008 wr_n  input  1  write strobe, active low.
REQ-009 test_addr  input  1  test-address qualifier.
REQ-010 lamp_reset_n  input  1  card reset from initiator, active low.
REQ-011 data_in  input  8  bus data sampled from pins.
REQ-012 data_out  output  8  bus data driven to pins.
REQ-013 data_oe  output  1  1 = drive data_out onto bus.
REQ-014 adc_in  input  32  four 8-bit ADC channels; channel n = adc_in[8n+7:8n].
REQ-015 lamp_out  output  32  lamp registers 0..3; reg n = lamp_out[8n+7:8n].
REQ-016 access_count  output  8  completed-access counter.
REQ-017 fault  output  1  sticky rd/wr contention flag.

Function
REQ-018 rd_n, wr_n, lamp_reset_n, board_x, addr, test_addr SHALL pass through SYNC_STAGES flops; data_in SHALL be registered one stage only.
REQ-019 Selected SHALL mean synchronized board_x == BOARD_ID.
REQ-020 FSM states SHALL be IDLE, READ, WRITE, FAULT.
REQ-021 IDLE->READ when selected and sync rd_n=0, wr_n=1; IDLE->WRITE when selected and sync wr_n=0, rd_n=1; IDLE->FAULT when selected and both 0.
REQ-022 On IDLE->READ the target SHALL latch addr; for addr 4..7 it SHALL snapshot adc channel (addr-4) into a read latch on that same edge.
REQ-023 In READ, data_oe SHALL be 1 and data_out SHALL hold the latched value (lamp reg for addr 0..3, ADC snapshot for 4..7), stable for the whole state.
REQ-024 Read latency: data_oe SHALL rise on the (SYNC_STAGES+1)th rising clock edge after rd_n falls at the pin.
REQ-025 READ->IDLE when sync rd_n=1; data_oe SHALL be 0 from that edge.
REQ-026 In WRITE the target SHALL track the registered data_in every cycle; on sync wr_n rising it SHALL commit the last tracked value to lamp reg addr (0..3) and return to IDLE.
REQ-027 Writes to addr 4..7 SHALL be discarded without other effect.
REQ-028 Sync rd_n falling while in WRITE, or sync wr_n falling while in READ, SHALL go to FAULT with no commit.
REQ-029 FAULT SHALL set fault=1 (sticky until reset), force data_oe=0, and return to IDLE once both sync strobes are 1.
REQ-030 access_count SHALL increment by 1 on every READ->IDLE and WRITE->IDLE transition, wrapping 8'hFF->8'h00; FAULT exits SHALL NOT count.
REQ-031 Deselection mid-access SHALL NOT abort it; completion follows the strobe only.
REQ-032 data_oe SHALL never be 1 outside READ.

Reset
REQ-033 reset=1 SHALL asynchronously clear the FSM to IDLE, lamp regs, read latch, data_out, data_oe, access_count, fault and all synchronizers (strobe syncs to 1).
REQ-034 Sync lamp_reset_n=0 SHALL synchronously clear lamp regs, force IDLE and data_oe=0 without committing; access_count and fault SHALL be preserved.

Configuration
REQ-035 Macro LAMP_CARD_TARGET_TESTADDR_EN defined: a read entered with sync test_addr=1 SHALL return {BOARD_ID, addr, 1'b1} instead of register data (no ADC snapshot taken).
REQ-036 Macro undefined: test_addr SHALL be ignored and reads SHALL return register data.

Verification
REQ-037 BOARD_ID=3: board_x=3, addr=2, data_in=8'hA5, wr_n low 6 clk then high -> lamp_out[23:16]=8'hA5, access_count=1.
REQ-038 Read addr=5 with adc_in[15:8]=8'h7C, change adc_in to 8'h00 mid-strobe -> data_oe high at edge 3 after rd_n fall, data_out=8'h7C throughout.
REQ-039 board_x=2 (BOARD_ID=3), write 8'hFF addr 0 -> lamp_out unchanged, data_oe stays 0, access_count unchanged.
REQ-040 Write in progress, rd_n pulled low -> fault=1, no register change, data_oe=0; both strobes high -> IDLE, access_count unchanged.
REQ-041 256 reads -> access_count wraps to 8'h00; then lamp_reset_n low 4 clk -> lamp_out=0, access_count still 8'h00.
REQ-042 Macro defined, BOARD_ID=3, test_addr=1, read addr=6 -> data_out=8'h3D; macro undefined -> register/ADC data.
